thing_feeder: RTL and testbench

THING_FEEDER -- requirements
Module: thing_feeder

---
 rtl/thing_feeder.sv | 105 ++++++++++
 tb/tb_thing_feeder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/thing_feeder.sv
// Item feeder: buffers upstream bytes in an 8-deep FIFO and issues them to the CIPU.
// ';' entries stall at the head until acknowledged; '$' ends the stream until reset.
module thing_feeder (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic [3:0] in_num,
   output logic       in_ready,
   input  logic       done_thing,
   output logic [7:0] thing_in,
   output logic [3:0] thing_num,
   output logic       thing_vld,
   output logic       stream_end
);

   localparam logic [7:0] DELIM_CH = 8'h3B;
   localparam logic [7:0] END_CH   = 8'h24;

   typedef enum logic [1:0] {ST_ISSUE, ST_DELIM, ST_END} state_t;

   state_t      state, state_nxt;
   logic [11:0] mem [8];
   logic [2:0]  wptr, rptr;
   logic [3:0]  count;
   logic        push, pop, load, set_end, empty;
   logic [7:0]  head_data;
   logic [3:0]  head_num;

   assign empty     = (count == 4'd0);
   assign head_data = mem[rptr][11:4];
   assign head_num  = mem[rptr][3:0];
   assign in_ready  = (count < 4'd8) && !stream_end;
   assign push      = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= {in_data, in_num};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 3'd1;
         if (pop)  rptr <= rptr + 3'd1;
         case ({push, pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_ISSUE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ISSUE: if (!empty) begin
            if (head_data == DELIM_CH)    state_nxt = ST_DELIM;
            else if (head_data == END_CH) state_nxt = ST_END;
         end
         ST_DELIM: if (done_thing) state_nxt = ST_ISSUE;
         default:  state_nxt = ST_END;
      endcase
   end

   // A delimiter is presented on entry to DELIM but only popped on acknowledge.
   always_comb begin
      pop     = 1'b0;
      load    = 1'b0;
      set_end = 1'b0;
      case (state)
         ST_ISSUE: if (!empty) begin
            load    = 1'b1;
            pop     = (head_data != DELIM_CH);
            set_end = (head_data == END_CH);
         end
         ST_DELIM: pop = done_thing;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         thing_in   <= 8'h00;
         thing_num  <= 4'h0;
         thing_vld  <= 1'b0;
         stream_end <= 1'b0;
      end else begin
         thing_vld <= load;
         if (load) begin
            thing_in  <= head_data;
            thing_num <= head_num;
         end
         if (set_end) stream_end <= 1'b1;
      end
   end

endmodule

// File: tb/tb_thing_feeder.sv
// Randomized and directed bench for thing_feeder against a queue-based reference model.
module tb_thing_feeder;

   logic       clk, rst, in_valid, done_thing;
   logic [7:0] in_data;
   logic [3:0] in_num;
   logic       in_ready, thing_vld, stream_end;
   logic [7:0] thing_in;
   logic [3:0] thing_num;

   int checks = 0;
   int errors = 0;

   thing_feeder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_num(in_num),
      .in_ready(in_ready), .done_thing(done_thing), .thing_in(thing_in),
      .thing_num(thing_num), .thing_vld(thing_vld), .stream_end(stream_end)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: buffered entries, waiting-for-ack flag, ended flag, last issued item.
   logic [11:0] q[$];
   logic [11:0] src[$];
   bit          m_wait, m_end, m_vld, m_acc;
   logic [7:0]  m_in;
   logic [3:0]  m_num;
   bit          done_drv = 1'b0;
   bit          vgate = 1'b1;

   function automatic logic [14:0] obs();
      return {in_ready, thing_vld, thing_in, thing_num, stream_end};
   endfunction

   function automatic logic [14:0] expv();
      return {(q.size() < 8) && !m_end, m_vld, m_in, m_num, m_end};
   endfunction

   task automatic model_reset();
      q.delete();
      src.delete();
      m_wait = 0; m_end = 0; m_vld = 0; m_acc = 0;
      m_in = 8'h00; m_num = 4'h0;
      done_drv = 0; vgate = 1;
   endtask

   // One clock: drive inputs from src/done_drv, advance the model, return #1 after the edge.
   task automatic tick();
      logic [11:0] h;
      bit rdy;
      in_valid   = (src.size() > 0) && vgate;
      {in_data, in_num} = (src.size() > 0) ? src[0] : 12'h000;
      done_thing = done_drv;
      rdy   = (q.size() < 8) && !m_end;
      m_vld = 0;
      if (!m_end) begin
         if (m_wait) begin
            if (done_drv) begin q.delete(0); m_wait = 0; end
         end else if (q.size() > 0) begin
            h = q[0];
            m_in = h[11:4]; m_num = h[3:0]; m_vld = 1;
            if (h[11:4] == 8'h3B) m_wait = 1;
            else begin
               q.delete(0);
               if (h[11:4] == 8'h24) m_end = 1;
            end
         end
      end
      m_acc = in_valid && rdy;
      if (m_acc) q.push_back({in_data, in_num});
      @(posedge clk); #1;
      if (m_acc) src.delete(0);
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      in_valid = 0; done_thing = 0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 0; in_data = 0; in_num = 0; done_thing = 0;
      model_reset();
      #1;
      checks++;
      if (obs() !== 15'b1_0_00000000_0000_0) begin
         errors++; $display("FAIL reset_state got %h want %h", obs(), 15'b1_0_00000000_0000_0);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1 || thing_vld !== 1'b0) begin
         errors++; $display("FAIL reset_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, thing_vld);
      end
   endtask

   task automatic test_stream();
      src.push_back({8'h41, 4'h0}); src.push_back({8'h42, 4'h1}); src.push_back({8'h43, 4'h2});
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL stream cyc%0d got %h want %h", i, obs(), expv());
         end
      end
   endtask

   task automatic test_delim();
      src.push_back({8'h3B, 4'h3}); src.push_back({8'h44, 4'h5});
      for (int i = 0; i < 12; i++) begin
         done_drv = (i == 7);
         tick();
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL delim cyc%0d got %h want %h", i, obs(), expv());
         end
      end
      done_drv = 0;
   endtask

   task automatic test_double_delim();
      src.push_back({8'h3B, 4'h1}); src.push_back({8'h3B, 4'h2}); src.push_back({8'h46, 4'h7});
      for (int i = 0; i < 14; i++) begin
         done_drv = (i == 5) || (i == 10);
         tick();
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL double_delim cyc%0d got %h want %h", i, obs(), expv());
         end
         if (i == 8) begin
            checks++;
            if (thing_in !== 8'h3B || thing_num !== 4'h2) begin
               errors++; $display("FAIL double_delim_second got %h/%h want 3b/2", thing_in, thing_num);
            end
         end
      end
      done_drv = 0;
   endtask

   task automatic test_full();
      src.push_back({8'h3B, 4'h5});
      for (int k = 0; k < 8; k++) src.push_back({8'h50 + 8'(k), 4'(k)});
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL full cyc%0d got %h want %h", i, obs(), expv());
         end
      end
      checks++;
      if (in_ready !== 1'b0 || src.size() != 1) begin
         errors++; $display("FAIL full_stall got rdy=%b pending=%0d want rdy=0 pending=1", in_ready, src.size());
      end
      for (int i = 0; i < 16; i++) begin
         done_drv = (i == 0);
         tick();
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL full_drain cyc%0d got %h want %h", i, obs(), expv());
         end
      end
      done_drv = 0;
   endtask

   task automatic test_end();
      src.push_back({8'h45, 4'h1}); src.push_back({8'h24, 4'h9}); src.push_back({8'h46, 4'h2});
      for (int i = 0; i < 10; i++) begin
         done_drv = i[0];
         tick();
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL end cyc%0d got %h want %h", i, obs(), expv());
         end
      end
      checks++;
      if (stream_end !== 1'b1 || thing_in !== 8'h24 || in_ready !== 1'b0) begin
         errors++; $display("FAIL end_final got end=%b in=%h rdy=%b want 1/24/0", stream_end, thing_in, in_ready);
      end
      apply_reset();
   endtask

   task automatic test_async_reset();
      src.push_back({8'h3B, 4'h6});
      for (int k = 0; k < 4; k++) src.push_back({8'h61 + 8'(k), 4'(k)});
      for (int i = 0; i < 7; i++) tick();
      checks++;
      if (obs() !== expv() || q.size() != 5) begin
         errors++; $display("FAIL async_setup got %h want %h", obs(), expv());
      end
      #3 rst = 1'b0;
      #1;
      checks++;
      if (obs() !== 15'b1_0_00000000_0000_0) begin
         errors++; $display("FAIL async_reset got %h want %h", obs(), 15'b1_0_00000000_0000_0);
      end
      model_reset();
      in_valid = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      src.push_back({8'h58, 4'h3}); src.push_back({8'h59, 4'h4});
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL async_after cyc%0d got %h want %h", i, obs(), expv());
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] d;
      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(0, 99) < 15) d = 8'h3B;
         else begin
            do d = 8'($urandom_range(0, 255)); while (d == 8'h3B || d == 8'h24);
         end
         src.push_back({d, 4'($urandom_range(0, 15))});
      end
      src.push_back({8'h24, 4'hA});
      src.push_back({8'h47, 4'h1});
      for (int i = 0; i < 400; i++) begin
         vgate    = ($urandom_range(0, 3) != 0);
         done_drv = ($urandom_range(0, 2) == 0);
         tick();
         checks++;
         if (obs() !== expv()) begin
            errors++; $display("FAIL random cyc%0d got %h want %h", i, obs(), expv());
         end
      end
      checks++;
      if (stream_end !== 1'b1) begin
         errors++; $display("FAIL random_end got %b want 1", stream_end);
      end
      apply_reset();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_delim();
      test_double_delim();
      test_full();
      test_end();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
